// File: rtl/tone_ctrl.sv
// tone_ctrl: play/pause/stop controller for a ROM-driven tone player.
// Tracks the song position, turns the current note code into a tone
// generator half-period divider (1 MHz base) and counts note advances.
// Optional macro TONE_CTRL_ARTIC_EN adds repeated-note articulation: the
// tone drops out for one beat when the same note is struck again.
module tone_ctrl #(
    parameter bit LOOP = 1'b1  // 1 = restart song at end, 0 = stop at end
) (
    input  logic        CLK4H,
    input  logic        RST_N,
    input  logic        PLAY_KEY,
    input  logic        STOP_KEY,
    input  logic [3:0]  INDEX,
    input  logic [6:0]  OADDR,
    output logic [10:0] TONE_DIV,
    output logic        TONE_EN,
    output logic        RUN,
    output logic [1:0]  PLAYING,
    output logic [7:0]  NOTE_CNT
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    state_t      state, next_state;
    logic        play_key_q;
    logic [6:0]  prev_oaddr;
    logic [3:0]  prev_index;
    logic [10:0] table_div;
    logic        rise;
    logic        song_end;
    logic        addr_change;
    logic        note_on;

    assign rise        = PLAY_KEY & ~play_key_q;
    assign addr_change = (OADDR != prev_oaddr);
    assign song_end    = (state == ST_PLAY) && (prev_oaddr == 7'd63) && (OADDR == 7'd1);

`ifdef TONE_CTRL_ARTIC_EN
    // A new address carrying the same sounding note gets one silent beat.
    logic repeat_note;
    assign repeat_note = addr_change && (prev_index != 4'd0) && (INDEX == prev_index);
    assign note_on     = (INDEX != 4'd0) && !repeat_note;
`else
    assign note_on     = (INDEX != 4'd0);
`endif

    // Note code to tone half-period divider lookup.
    always_comb begin
        unique case (INDEX)
            4'd0:    table_div = 11'd0;
            4'd1:    table_div = 11'd1911;
            4'd2:    table_div = 11'd1703;
            4'd3:    table_div = 11'd1517;
            4'd4:    table_div = 11'd1432;
            4'd5:    table_div = 11'd1276;
            4'd6:    table_div = 11'd1136;
            4'd7:    table_div = 11'd1012;
            4'd8:    table_div = 11'd956;
            4'd9:    table_div = 11'd851;
            4'd10:   table_div = 11'd758;
            4'd11:   table_div = 11'd716;
            4'd12:   table_div = 11'd638;
            4'd13:   table_div = 11'd568;
            4'd14:   table_div = 11'd506;
            default: table_div = 11'd478;
        endcase
    end

    // Next-state logic; STOP_KEY outranks a key rise, a rise outranks song end.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves next_state unassigned (latch).
        next_state = ST_STOP;
        case (state)
            ST_STOP: begin
                next_state = rise ? ST_PLAY : ST_STOP;
            end
            ST_PLAY: begin
                if (STOP_KEY)
                    next_state = ST_STOP;
                else if (rise)
                    next_state = ST_PAUSE;
                else if (song_end && !LOOP)
                    next_state = ST_STOP;
                else
                    next_state = ST_PLAY;
            end
            ST_PAUSE: begin
                if (STOP_KEY)
                    next_state = ST_STOP;
                else if (rise)
                    next_state = ST_PLAY;
                else
                    next_state = ST_PAUSE;
            end
            default: next_state = ST_STOP;  // code 11 recovers to STOP
        endcase
    end

    // State, key history and input history registers.
    always_ff @(posedge CLK4H or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_STOP;
            play_key_q <= 1'b0;
            prev_oaddr <= 7'd1;
            prev_index <= 4'd0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values of the others.
            state      <= next_state;
            play_key_q <= PLAY_KEY;
            prev_oaddr <= OADDR;
            prev_index <= INDEX;
        end
    end

    // Registered state outputs, aligned with the state register.
    always_ff @(posedge CLK4H or negedge RST_N) begin
        if (!RST_N) begin
            RUN     <= 1'b0;
            PLAYING <= 2'b00;
        end else begin
            RUN     <= (next_state == ST_PLAY);
            PLAYING <= next_state;
        end
    end

    // Tone outputs: load from the table only while staying in PLAY,
    // zero on entering or staying in STOP, otherwise hold the divider muted.
    always_ff @(posedge CLK4H or negedge RST_N) begin
        if (!RST_N) begin
            TONE_DIV <= 11'd0;
            TONE_EN  <= 1'b0;
        end else if (next_state == ST_STOP) begin
            TONE_DIV <= 11'd0;
            TONE_EN  <= 1'b0;
        end else if ((state == ST_PLAY) && (next_state == ST_PLAY)) begin
            TONE_DIV <= table_div;
            TONE_EN  <= note_on;
        end else begin
            TONE_EN  <= 1'b0;
        end
    end

    // Saturating count of address advances, cleared on entry to STOP.
    always_ff @(posedge CLK4H or negedge RST_N) begin
        if (!RST_N) begin
            NOTE_CNT <= 8'd0;
        end else if ((next_state == ST_STOP) && (state != ST_STOP)) begin
            NOTE_CNT <= 8'd0;
        end else if ((state == ST_PLAY) && addr_change && (NOTE_CNT != 8'hFF)) begin
            NOTE_CNT <= NOTE_CNT + 8'd1;
        end
    end

endmodule

// File: tb/tb_tone_ctrl.sv
// tb_tone_ctrl: directed checks of tone_ctrl. Two instances share stimulus:
// dut_l1 (LOOP=1) carries most checks, dut_l0 (LOOP=0) covers song end stop.
// Inputs change 1 time unit after a rising edge; outputs are read there too.
module tb_tone_ctrl;

    logic        CLK4H = 1'b0;
    logic        RST_N;
    logic        PLAY_KEY;
    logic        STOP_KEY;
    logic [3:0]  INDEX;
    logic [6:0]  OADDR;
    logic [10:0] div1, div0;
    logic        en1, en0, run1, run0;
    logic [1:0]  pl1, pl0;
    logic [7:0]  cnt1, cnt0;
    int          checks = 0;
    int          errors = 0;

    always #5 CLK4H = ~CLK4H;

    tone_ctrl #(.LOOP(1'b1)) dut_l1 (
        .CLK4H(CLK4H), .RST_N(RST_N), .PLAY_KEY(PLAY_KEY), .STOP_KEY(STOP_KEY),
        .INDEX(INDEX), .OADDR(OADDR), .TONE_DIV(div1), .TONE_EN(en1),
        .RUN(run1), .PLAYING(pl1), .NOTE_CNT(cnt1)
    );

    tone_ctrl #(.LOOP(1'b0)) dut_l0 (
        .CLK4H(CLK4H), .RST_N(RST_N), .PLAY_KEY(PLAY_KEY), .STOP_KEY(STOP_KEY),
        .INDEX(INDEX), .OADDR(OADDR), .TONE_DIV(div0), .TONE_EN(en0),
        .RUN(run0), .PLAYING(pl0), .NOTE_CNT(cnt0)
    );

    task automatic step();
        @(posedge CLK4H);
        #1;
    endtask

    task automatic apply_reset();
        PLAY_KEY = 1'b0; STOP_KEY = 1'b0; INDEX = 4'd0; OADDR = 7'd1;
        RST_N = 1'b0;
        step();
        step();
        #2 RST_N = 1'b1;
        step();
    endtask

    task automatic test_reset();
        PLAY_KEY = 1'b0; STOP_KEY = 1'b0; INDEX = 4'd5; OADDR = 7'd1;
        RST_N = 1'b0;
        step();
        checks++; if (div1 !== 11'd0) begin errors++; $display("FAIL reset_div got %0d exp 0", div1); end
        checks++; if (en1 !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", en1); end
        checks++; if (run1 !== 1'b0) begin errors++; $display("FAIL reset_run got %b exp 0", run1); end
        checks++; if (pl1 !== 2'b00) begin errors++; $display("FAIL reset_playing got %b exp 00", pl1); end
        checks++; if (cnt1 !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt1); end
        #2 RST_N = 1'b1;
        INDEX = 4'd0;
        step();
        step();
        checks++; if (pl1 !== 2'b00) begin errors++; $display("FAIL idle_after_reset got %b exp 00", pl1); end
    endtask

    task automatic test_play_start();
        INDEX = 4'd6; PLAY_KEY = 1'b1;
        step();
        checks++; if (pl1 !== 2'b01) begin errors++; $display("FAIL start_playing got %b exp 01", pl1); end
        checks++; if (run1 !== 1'b1) begin errors++; $display("FAIL start_run got %b exp 1", run1); end
        checks++; if (en1 !== 1'b0) begin errors++; $display("FAIL start_en_latency got %b exp 0", en1); end
        step();
        checks++; if (div1 !== 11'd1136) begin errors++; $display("FAIL start_div got %0d exp 1136", div1); end
        checks++; if (en1 !== 1'b1) begin errors++; $display("FAIL start_en got %b exp 1", en1); end
        checks++; if (cnt1 !== 8'd0) begin errors++; $display("FAIL start_cnt got %0d exp 0", cnt1); end
    endtask

    task automatic test_rest_pause();
        INDEX = 4'd0;
        step();
        checks++; if (div1 !== 11'd0) begin errors++; $display("FAIL rest_div got %0d exp 0", div1); end
        checks++; if (en1 !== 1'b0) begin errors++; $display("FAIL rest_en got %b exp 0", en1); end
        INDEX = 4'd3; PLAY_KEY = 1'b0;
        step();
        checks++; if (div1 !== 11'd1517) begin errors++; $display("FAIL e4_div got %0d exp 1517", div1); end
        checks++; if (en1 !== 1'b1) begin errors++; $display("FAIL e4_en got %b exp 1", en1); end
        PLAY_KEY = 1'b1; INDEX = 4'd9;
        step();
        checks++; if (pl1 !== 2'b10) begin errors++; $display("FAIL pause_playing got %b exp 10", pl1); end
        checks++; if (run1 !== 1'b0) begin errors++; $display("FAIL pause_run got %b exp 0", run1); end
        checks++; if (en1 !== 1'b0) begin errors++; $display("FAIL pause_en got %b exp 0", en1); end
        checks++; if (div1 !== 11'd1517) begin errors++; $display("FAIL pause_div_hold got %0d exp 1517", div1); end
        PLAY_KEY = 1'b0; INDEX = 4'd3;
        step();
        checks++; if (pl1 !== 2'b10) begin errors++; $display("FAIL pause_stays got %b exp 10", pl1); end
        PLAY_KEY = 1'b1;
        step();
        checks++; if (pl1 !== 2'b01) begin errors++; $display("FAIL resume_playing got %b exp 01", pl1); end
        step();
        checks++; if (en1 !== 1'b1) begin errors++; $display("FAIL resume_en got %b exp 1", en1); end
        checks++; if (div1 !== 11'd1517) begin errors++; $display("FAIL resume_div got %0d exp 1517", div1); end
        OADDR = 7'd2;
        step();
        checks++; if (cnt1 !== 8'd1) begin errors++; $display("FAIL cnt_first got %0d exp 1", cnt1); end
        OADDR = 7'd3;
        step();
        step();
        checks++; if (cnt1 !== 8'd2) begin errors++; $display("FAIL cnt_second got %0d exp 2", cnt1); end
    endtask

    task automatic test_stop_priority();
        PLAY_KEY = 1'b0;
        step();
        PLAY_KEY = 1'b1;
        step();
        checks++; if (pl1 !== 2'b10) begin errors++; $display("FAIL prio_pause got %b exp 10", pl1); end
        PLAY_KEY = 1'b0;
        step();
        PLAY_KEY = 1'b1; STOP_KEY = 1'b1;
        step();
        checks++; if (pl1 !== 2'b00) begin errors++; $display("FAIL prio_playing got %b exp 00", pl1); end
        checks++; if (cnt1 !== 8'd0) begin errors++; $display("FAIL prio_cnt got %0d exp 0", cnt1); end
        checks++; if (div1 !== 11'd0) begin errors++; $display("FAIL prio_div got %0d exp 0", div1); end
        PLAY_KEY = 1'b0; STOP_KEY = 1'b0;
        step();
        checks++; if (pl1 !== 2'b00) begin errors++; $display("FAIL prio_stays got %b exp 00", pl1); end
    endtask

    task automatic test_song_end();
        OADDR = 7'd62;
        step();
        PLAY_KEY = 1'b1;
        step();
        checks++; if (pl0 !== 2'b01) begin errors++; $display("FAIL end_start_l0 got %b exp 01", pl0); end
        PLAY_KEY = 1'b0; OADDR = 7'd63;
        step();
        checks++; if (cnt0 !== 8'd1) begin errors++; $display("FAIL end_cnt63_l0 got %0d exp 1", cnt0); end
        OADDR = 7'd1;
        step();
        checks++; if (pl0 !== 2'b00) begin errors++; $display("FAIL end_stop_l0 got %b exp 00", pl0); end
        checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL end_cnt_l0 got %0d exp 0", cnt0); end
        checks++; if (pl1 !== 2'b01) begin errors++; $display("FAIL end_loop_l1 got %b exp 01", pl1); end
        checks++; if (cnt1 !== 8'd2) begin errors++; $display("FAIL end_cnt_l1 got %0d exp 2", cnt1); end
        OADDR = 7'd2;
        step();
        checks++; if (cnt1 !== 8'd3) begin errors++; $display("FAIL loop_cnt_l1 got %0d exp 3", cnt1); end
        checks++; if (pl0 !== 2'b00) begin errors++; $display("FAIL end_held_l0 got %b exp 00", pl0); end
    endtask

    task automatic test_saturate();
        apply_reset();
        INDEX = 4'd5; PLAY_KEY = 1'b1;
        step();
        PLAY_KEY = 1'b0;
        for (int i = 0; i < 300; i++) begin
            OADDR = 7'((i % 100) + 2);
            step();
            if (i == 0 || i == 99 || i == 254 || i == 299) begin
                checks++;
                if (cnt1 !== ((i + 1 > 255) ? 8'd255 : 8'(i + 1))) begin
                    errors++; $display("FAIL sat_cnt step %0d got %0d exp %0d", i, cnt1, (i + 1 > 255) ? 255 : i + 1);
                end
            end
        end
        step();
        checks++; if (cnt1 !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d exp 255", cnt1); end
    endtask

    task automatic test_artic();
        INDEX = 4'd8; OADDR = 7'd40;
        step();
        checks++; if (div1 !== 11'd956) begin errors++; $display("FAIL artic_first_div got %0d exp 956", div1); end
        checks++; if (en1 !== 1'b1) begin errors++; $display("FAIL artic_first_en got %b exp 1", en1); end
        OADDR = 7'd41;
        step();
        checks++; if (div1 !== 11'd956) begin errors++; $display("FAIL artic_repeat_div got %0d exp 956", div1); end
`ifdef TONE_CTRL_ARTIC_EN
        checks++; if (en1 !== 1'b0) begin errors++; $display("FAIL artic_gap_en got %b exp 0", en1); end
`else
        checks++; if (en1 !== 1'b1) begin errors++; $display("FAIL artic_cont_en got %b exp 1", en1); end
`endif
        step();
        checks++; if (en1 !== 1'b1) begin errors++; $display("FAIL artic_after_en got %b exp 1", en1); end
        checks++; if (div1 !== 11'd956) begin errors++; $display("FAIL artic_after_div got %0d exp 956", div1); end
    endtask

    task automatic test_async_reset();
        checks++; if (en1 !== 1'b1) begin errors++; $display("FAIL async_pre_en got %b exp 1", en1); end
        #2 RST_N = 1'b0;
        #1;
        checks++; if (en1 !== 1'b0) begin errors++; $display("FAIL async_en got %b exp 0", en1); end
        checks++; if (div1 !== 11'd0) begin errors++; $display("FAIL async_div got %0d exp 0", div1); end
        step();
        #2 RST_N = 1'b1;
        PLAY_KEY = 1'b0;
        step();
        step();
        checks++; if (pl1 !== 2'b00) begin errors++; $display("FAIL async_stays_stop got %b exp 00", pl1); end
        PLAY_KEY = 1'b1;
        step();
        checks++; if (pl1 !== 2'b01) begin errors++; $display("FAIL async_restart got %b exp 01", pl1); end
    endtask

    initial begin
        test_reset();
        test_play_start();
        test_rest_pause();
        test_stop_priority();
        test_song_end();
        test_saturate();
        test_artic();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
